// File: rtl/uart_pkg.sv
// Shared types and constants for the uart transmit arbiter.
package uart_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_DRAIN = 2'd2
    } uart_arb_state_t;

    localparam int UART_DATA_BITS_DEFAULT = 8;
    localparam int UART_NUM_REQ_DEFAULT   = 4;

    // Index width for a requester vector; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and uart-side handshake bundle of the transmit arbiter.
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS_DEFAULT,
    parameter int NUM_REQ   = UART_NUM_REQ_DEFAULT
);
    localparam int IDX_W = idx_width(NUM_REQ);

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*DATA_BITS-1:0] req_data;
    logic [NUM_REQ-1:0]           req_ack;
    logic [DATA_BITS-1:0]         uart_tx_input;
    logic                         uart_new_data;
    logic                         uart_ready;
    logic [IDX_W-1:0]             grant_id;
    logic                         busy;

    modport master (
        output req_valid, req_data, uart_ready,
        input  req_ack, uart_tx_input, uart_new_data, grant_id, busy
    );

    modport slave (
        input  req_valid, req_data, uart_ready,
        output req_ack, uart_tx_input, uart_new_data, grant_id, busy
    );

endinterface

// File: rtl/uart_rr_picker.sv
// Round-robin winner search: rotate the request vector so the search starts
// at ptr+1, take the lowest set bit, and map it back to a requester index.
module uart_rr_picker
    import uart_pkg::*;
#(
    parameter  int NUM_REQ = UART_NUM_REQ_DEFAULT,
    localparam int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               any,
    output logic [IDX_W-1:0]   idx
);

    logic [NUM_REQ-1:0] rot_s;
    logic [IDX_W-1:0]   off_s;
    logic [IDX_W-1:0]   src_s;

    // Rotate, priority-encode from the bottom, then un-rotate.
    always_comb begin
        rot_s = '0;
        off_s = '0;
        src_s = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            src_s    = IDX_W'((int'(ptr) + 1 + k) % NUM_REQ);
            rot_s[k] = req[src_s];
        end
        any = |rot_s;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            off_s = rot_s[k] ? IDX_W'(k) : off_s;
        end
        idx = IDX_W'((int'(off_s) + int'(ptr) + 1) % NUM_REQ);
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart transmitter between NUM_REQ byte producers, round-robin.
// Optional build macro UART_ARB_PRIO0_EN gives requester 0 strict priority.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS_DEFAULT,
    parameter int NUM_REQ   = UART_NUM_REQ_DEFAULT
) (
    input logic              clk,
    input logic              rst_n,
    uart_tx_arbiter_if.slave bus
);

    localparam int IDX_W = idx_width(NUM_REQ);

    uart_arb_state_t      state_r, state_nxt_s;
    logic [IDX_W-1:0]     rr_ptr_r, rr_ptr_nxt_s;
    logic [IDX_W-1:0]     grant_r, grant_nxt_s;
    logic [NUM_REQ-1:0]   ack_r, ack_nxt_s;
    logic [DATA_BITS-1:0] tx_r, tx_nxt_s;
    logic                 new_data_r, new_data_nxt_s;
    logic                 busy_r;

    logic [NUM_REQ-1:0]   pick_req_s;
    logic                 pick_any_s;
    logic [IDX_W-1:0]     pick_idx_s;
    logic                 win_any_s;
    logic [IDX_W-1:0]     win_s;
    logic                 win_upd_s;

    uart_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req (pick_req_s),
        .ptr (rr_ptr_r),
        .any (pick_any_s),
        .idx (pick_idx_s)
    );

`ifdef UART_ARB_PRIO0_EN
    // Requester 0 pre-empts the rotation and leaves the pointer alone.
    assign pick_req_s = bus.req_valid & {{(NUM_REQ-1){1'b1}}, 1'b0};

    // Winner selection with requester 0 in front.
    always_comb begin
        if (bus.req_valid[0]) begin
            win_any_s = 1'b1;
            win_s     = '0;
            win_upd_s = 1'b0;
        end else begin
            win_any_s = pick_any_s;
            win_s     = pick_idx_s;
            win_upd_s = 1'b1;
        end
    end
`else
    assign pick_req_s = bus.req_valid;

    // Winner selection, pure rotation.
    always_comb begin
        win_any_s = pick_any_s;
        win_s     = pick_idx_s;
        win_upd_s = 1'b1;
    end
`endif

    // Next-state and next-output logic of the frame sequencer.
    always_comb begin
        state_nxt_s    = state_r;
        rr_ptr_nxt_s   = rr_ptr_r;
        grant_nxt_s    = grant_r;
        tx_nxt_s       = tx_r;
        ack_nxt_s      = '0;
        new_data_nxt_s = new_data_r;
        case (state_r)
            ARB_IDLE: begin
                if (bus.uart_ready && win_any_s) begin
                    state_nxt_s    = ARB_ISSUE;
                    grant_nxt_s    = win_s;
                    rr_ptr_nxt_s   = win_upd_s ? win_s : rr_ptr_r;
                    tx_nxt_s       = bus.req_data[win_s*DATA_BITS +: DATA_BITS];
                    ack_nxt_s      = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_s;
                    new_data_nxt_s = 1'b1;
                end else begin
                    new_data_nxt_s = 1'b0;
                end
            end
            ARB_ISSUE: begin
                // ready low means the uart has taken the word
                if (!bus.uart_ready) begin
                    new_data_nxt_s = 1'b0;
                    state_nxt_s    = ARB_DRAIN;
                end else begin
                    new_data_nxt_s = 1'b1;
                end
            end
            ARB_DRAIN: begin
                if (bus.uart_ready) begin
                    state_nxt_s = ARB_IDLE;
                end else begin
                    state_nxt_s = ARB_DRAIN;
                end
            end
            default: begin
                state_nxt_s    = ARB_IDLE;
                new_data_nxt_s = 1'b0;
            end
        endcase
    end

    // State and registered outputs; pointer resets so requester 0 goes first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ARB_IDLE;
            rr_ptr_r   <= IDX_W'(NUM_REQ - 1);
            grant_r    <= '0;
            tx_r       <= '0;
            ack_r      <= '0;
            new_data_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            rr_ptr_r   <= rr_ptr_nxt_s;
            grant_r    <= grant_nxt_s;
            tx_r       <= tx_nxt_s;
            ack_r      <= ack_nxt_s;
            new_data_r <= new_data_nxt_s;
            busy_r     <= (state_nxt_s != ARB_IDLE);
        end
    end

    assign bus.req_ack       = ack_r;
    assign bus.uart_tx_input = tx_r;
    assign bus.uart_new_data = new_data_r;
    assign bus.grant_id      = grant_r;
    assign bus.busy          = busy_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small uart model and line receiver.
// Build with UART_ARB_PRIO0_EN defined to check the priority variant.
module tb_uart_tx_arbiter;

    localparam int DATA_BITS = 8;
    localparam int NUM_REQ   = 4;
    localparam int BIT_CLKS  = 8;

    logic clk;
    logic rst_n;
    logic urst_n;
    logic tx_wire;
    logic [8:0] shreg;
    int clkcnt;
    int bitcnt;
    logic [8:0] rx_fr;
    logic [8:0] rx_q[$];

    int n_cmp;
    int n_bad;

    uart_tx_arbiter_if #(.DATA_BITS(DATA_BITS), .NUM_REQ(NUM_REQ)) bus_if ();

    uart_tx_arbiter #(.DATA_BITS(DATA_BITS), .NUM_REQ(NUM_REQ)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Uart model: start bit, 8 data bits LSB first, stop bit; ready=1 when idle.
    always @(posedge clk) begin
        if (!urst_n) begin
            bus_if.uart_ready <= 1'b1;
            tx_wire <= 1'b1;
            shreg   <= '0;
            clkcnt  <= 0;
            bitcnt  <= 0;
        end else if (bus_if.uart_ready) begin
            if (bus_if.uart_new_data) begin
                shreg   <= {1'b1, bus_if.uart_tx_input};
                tx_wire <= 1'b0;
                bus_if.uart_ready <= 1'b0;
                clkcnt  <= 0;
                bitcnt  <= 0;
            end
        end else if (clkcnt == BIT_CLKS - 1) begin
            clkcnt <= 0;
            if (bitcnt == 9) begin
                bus_if.uart_ready <= 1'b1;
            end else begin
                tx_wire <= shreg[0];
                shreg   <= shreg >> 1;
                bitcnt  <= bitcnt + 1;
            end
        end else begin
            clkcnt <= clkcnt + 1;
        end
    end

    // Line receiver: sample mid-bit, queue {stop, byte}.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_wire === 1'b0) begin
                repeat (BIT_CLKS / 2) @(negedge clk);
                for (int b = 0; b < 9; b++) begin
                    repeat (BIT_CLKS) @(negedge clk);
                    rx_fr[b] = tx_wire;
                end
                rx_q.push_back(rx_fr);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_ack(output int idx, output int cyc);
        idx = -1;
        cyc = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            cyc++;
            if (|bus_if.req_ack) begin
                for (int j = 0; j < NUM_REQ; j++) begin
                    if (bus_if.req_ack[j]) idx = j;
                end
                check_value("ack_onehot", $countones(bus_if.req_ack), 1);
                break;
            end
        end
    endtask

    task automatic wait_rx(input int n);
        for (int c = 0; c < 3000; c++) begin
            if (rx_q.size() >= n) break;
            @(negedge clk);
        end
        check_value("rx_count", rx_q.size(), n);
    endtask

    task automatic check_rx(input string tag, input logic [7:0] b);
        logic [8:0] fr;
        fr = 9'h000;
        if (rx_q.size() > 0) fr = rx_q.pop_front();
        check_value(tag, {23'd0, fr}, {23'd0, 1'b1, b});
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (!bus_if.busy && bus_if.uart_ready) break;
        end
        check_value("idle_busy", bus_if.busy, 0);
    endtask

    task automatic serve(input string tag, input int exp_idx, input logic [7:0] exp_byte);
        int idx;
        int cyc;
        wait_ack(idx, cyc);
        check_value({tag, "_idx"}, idx, exp_idx);
        check_value({tag, "_gid"}, bus_if.grant_id, exp_idx);
        check_value({tag, "_txin"}, bus_if.uart_tx_input, exp_byte);
        if (idx >= 0) bus_if.req_valid[idx] = 1'b0;
    endtask

    initial begin
        int idx;
        int cyc;
        int ones;
        int early;
        int exp6[4];
        logic [7:0] b6[4];

        n_cmp = 0;
        n_bad = 0;
        rst_n  = 1'b0;
        urst_n = 1'b0;
        bus_if.req_valid = '0;
        bus_if.req_data  = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check_value("rst_ack", bus_if.req_ack, 0);
        check_value("rst_newdata", bus_if.uart_new_data, 0);
        check_value("rst_txin", bus_if.uart_tx_input, 0);
        check_value("rst_gid", bus_if.grant_id, 0);
        check_value("rst_busy", bus_if.busy, 0);
        rst_n  = 1'b1;
        urst_n = 1'b1;

        // 1: idle line for 10 bit times
        ones = 0;
        for (int t = 0; t < 10; t++) begin
            repeat (BIT_CLKS) @(negedge clk);
            if (tx_wire === 1'b1) ones++;
        end
        check_value("idle_line", ones, 10);
        check_value("idle_busy0", bus_if.busy, 0);
        check_value("idle_ack0", bus_if.req_ack, 0);

        // 2: single byte, latency and frame
        bus_if.req_data[7:0] = 8'hA5;
        bus_if.req_valid = 4'b0001;
        wait_ack(idx, cyc);
        check_value("t2_latency", cyc, 1);
        check_value("t2_ack", bus_if.req_ack, 4'b0001);
        check_value("t2_newdata", bus_if.uart_new_data, 1);
        check_value("t2_gid", bus_if.grant_id, 0);
        check_value("t2_txin", bus_if.uart_tx_input, 8'hA5);
        check_value("t2_busy", bus_if.busy, 1);
        bus_if.req_valid = 4'b0000;
        @(negedge clk);
        check_value("t2_ack_pulse", bus_if.req_ack, 0);
        check_value("t2_newdata_hold", bus_if.uart_new_data, 1);
        wait_rx(1);
        check_rx("t2_frame", 8'hA5);
        wait_idle();

        // 3: all four at once after reset
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus_if.req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        bus_if.req_valid = 4'b1111;
        serve("t3_g0", 0, 8'h11);
        serve("t3_g1", 1, 8'h22);
        serve("t3_g2", 2, 8'h33);
        serve("t3_g3", 3, 8'h44);
        wait_rx(4);
        check_rx("t3_f0", 8'h11);
        check_rx("t3_f1", 8'h22);
        check_rx("t3_f2", 8'h33);
        check_rx("t3_f3", 8'h44);
        wait_idle();

        // 4: held requester does not starve a later one
        bus_if.req_data[15:8] = 8'h5A;
        bus_if.req_valid[1] = 1'b1;
        wait_ack(idx, cyc);
        check_value("t4_first", idx, 1);
        early = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (|bus_if.req_ack) early++;
        end
        check_value("t4_no_ack_busy", early, 0);
        bus_if.req_data[23:16] = 8'h6B;
        bus_if.req_valid[2] = 1'b1;
        serve("t4_g2", 2, 8'h6B);
        serve("t4_g1", 1, 8'h5A);
        wait_rx(3);
        check_rx("t4_f0", 8'h5A);
        check_rx("t4_f1", 8'h6B);
        check_rx("t4_f2", 8'h5A);
        wait_idle();

        // 5: reset while a frame is in flight
        bus_if.req_data[23:16] = 8'h77;
        bus_if.req_valid = 4'b0100;
        serve("t5_g2", 2, 8'h77);
        @(negedge clk);
        check_value("t5_newdata_pre", bus_if.uart_new_data, 1);
        check_value("t5_ready_pre", bus_if.uart_ready, 0);
        rst_n = 1'b0;
        #1;
        check_value("t5_newdata_async", bus_if.uart_new_data, 0);
        check_value("t5_busy_async", bus_if.busy, 0);
        bus_if.req_data[15:8]  = 8'h81;
        bus_if.req_data[31:24] = 8'h83;
        bus_if.req_valid = 4'b1010;
        @(negedge clk);
        rst_n = 1'b1;
        early = 0;
        for (int c = 0; c < 2000; c++) begin
            if (|bus_if.req_ack) early++;
            if (bus_if.uart_ready) break;
            @(negedge clk);
        end
        check_value("t5_no_ack_inflight", early, 0);
        serve("t5_g1", 1, 8'h81);
        serve("t5_g3", 3, 8'h83);
        wait_rx(3);
        check_rx("t5_f0", 8'h77);
        check_rx("t5_f1", 8'h81);
        check_rx("t5_f2", 8'h83);
        wait_idle();

        // 6: requester 0 arrives while 1..3 are pending
`ifdef UART_ARB_PRIO0_EN
        exp6 = '{1, 0, 2, 3};
`else
        exp6 = '{1, 2, 3, 0};
`endif
        b6 = '{8'h90, 8'h91, 8'h92, 8'h93};
        bus_if.req_data  = {8'h93, 8'h92, 8'h91, 8'h90};
        bus_if.req_valid = 4'b1110;
        serve("t6_g0", exp6[0], b6[exp6[0]]);
        repeat (20) @(negedge clk);
        bus_if.req_valid[0] = 1'b1;
        serve("t6_g1", exp6[1], b6[exp6[1]]);
        serve("t6_g2", exp6[2], b6[exp6[2]]);
        serve("t6_g3", exp6[3], b6[exp6[3]]);
        wait_rx(4);
        check_rx("t6_f0", b6[exp6[0]]);
        check_rx("t6_f1", b6[exp6[1]]);
        check_rx("t6_f2", b6[exp6[2]]);
        check_rx("t6_f3", b6[exp6[3]]);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
